// File: rtl/mc_stack_pkg.sv
// Shared opcode, FSM state and instruction-field definitions for the multicycle stack core.
package mc_stack_pkg;

    localparam int OP_W = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam int ST_W = 4;
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_POP_B  = 4'd2;
    localparam logic [3:0] S_POP_A  = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_LOAD   = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;
    localparam logic [3:0] S_ERROR  = 4'd8;

    // Opcode lives in the top OP_W bits of the instruction word.
    function automatic int op_lsb(input int data_w);
        return data_w - OP_W;
    endfunction

    function automatic logic is_binop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/mc_stack_file.sv
// Operand stack: DEPTH x DATA_W storage plus stack pointer.
// MC_STACK_CHECK_EN selects a 0..DEPTH pointer; otherwise the pointer wraps modulo DEPTH.
module mc_stack_file
    import mc_stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int SPW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] top,
    output logic [SPW-1:0]    sp,
    output logic              full,
    output logic              empty
);

    localparam int IW = SPW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_m1;
    logic [SPW-1:0]    sp_inc;
    logic [SPW-1:0]    sp_dec;

    assign idx    = sp[IW-1:0];
    assign idx_m1 = idx - 1'b1;
    assign top    = mem[idx_m1];
    assign full   = (sp == SPW'(DEPTH));
    assign empty  = (sp == '0);

`ifdef MC_STACK_CHECK_EN
    assign sp_inc = sp + 1'b1;
    assign sp_dec = sp - 1'b1;
`else
    // Pointer stays inside 0..DEPTH-1, so over-pushes overwrite the oldest slot.
    assign sp_inc = {1'b0, idx + 1'b1};
    assign sp_dec = {1'b0, idx_m1};
`endif

    // Contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[idx] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sp <= '0;
        else if (push)
            sp <= sp_inc;
        else if (pop)
            sp <= sp_dec;
    end

endmodule

// File: rtl/stack_mc_core.sv
// Multicycle stack-machine core driving a single-port word memory.
// MC_STACK_CHECK_EN enables stack underflow/overflow trapping into the ERROR state.
module stack_mc_core
    import mc_stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Done,
    output logic              err
);

    localparam int SPW    = $clog2(DEPTH) + 1;
    localparam int OP_LSB = op_lsb(DATA_W);

`ifdef MC_STACK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic [ST_W-1:0]   state;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        op;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] top;
    logic [SPW-1:0]    sp;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              uf1;
    logic              uf2;
    logic              ovf;

    assign uf1 = CHK && empty;
    assign uf2 = CHK && (sp < SPW'(2));
    assign ovf = CHK && full;

    assign push = (state == S_EXEC) || (state == S_LOAD);
    assign pop  = (state == S_POP_B) || (state == S_POP_A) || (state == S_STORE);

    mc_stack_file #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SPW(SPW)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (state == S_LOAD ? mem_rdata : alu),
        .top   (top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        alu = ~a;
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            default: alu = ~a;
        endcase
    end

    assign mem_addr  = (state == S_LOAD || state == S_STORE) ? ir_addr : pc;
    assign mem_wdata = top;
    // Reset in the STORE cycle must suppress the write committing on that edge.
    assign mem_we    = (state == S_STORE) && !rst;
    assign Done      = (state == S_HALT) || (state == S_ERROR);
    assign err       = CHK && (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    op      <= mem_rdata[OP_LSB +: OP_W];
                    ir_addr <= mem_rdata[ADDR_W-1:0];
                    pc      <= pc + 1'b1;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_NOT:  state <= uf1 ? S_ERROR : S_POP_A;
                        OP_PUSH: state <= ovf ? S_ERROR : S_LOAD;
                        OP_POP:  state <= uf1 ? S_ERROR : S_STORE;
                        OP_JMP: begin
                            if (ir_addr == pc - 1'b1) begin
                                state <= S_HALT;
                            end else begin
                                pc    <= ir_addr;
                                state <= S_FETCH;
                            end
                        end
                        OP_JZ: begin
                            if (uf1) begin
                                state <= S_ERROR;
                            end else begin
                                if (top == '0)
                                    pc <= ir_addr;
                                state <= S_FETCH;
                            end
                        end
                        default: state <= (is_binop(op) && uf2) ? S_ERROR : S_POP_B;
                    endcase
                end
                S_POP_B: begin
                    b     <= top;
                    state <= S_POP_A;
                end
                S_POP_A: begin
                    a     <= top;
                    state <= S_EXEC;
                end
                S_EXEC, S_LOAD, S_STORE: state <= S_FETCH;
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mc_core.sv
// Self-checking bench for stack_mc_core: memory model plus write scoreboard.
module tb_stack_mc_core;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          Done;
    logic          err;

    stack_mc_core #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .Done      (Done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] mem [32];
    wr_t           exp_q[$];
    int            total = 0;
    int            bad   = 0;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Writes are observed mid-cycle and committed to the model at the following edge.
    logic          wr_pend = 1'b0;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    always @(negedge clk) begin
        wr_t e;
        wr_pend = mem_we;
        wr_a    = mem_addr;
        wr_d    = mem_wdata;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexp_wr", 32'(mem_addr), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    always @(posedge clk) begin
        if (wr_pend)
            mem[wr_a] = wr_d;
    end

    task automatic clear_mem;
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] ad, input logic [DW-1:0] d);
        wr_t e;
        e.addr = ad;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        step(2);
        chk("rst_done", 32'(Done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input int exp_cyc, input logic exp_err);
        int cyc;
        cyc = 0;
        while (!Done && cyc < 200) begin
            step(1);
            cyc++;
        end
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_done"}, 32'(Done), 1);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        step(4);
        chk({tag, "_hold"}, 32'(Done), 1);
        chk({tag, "_q"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        // arithmetic: 5 - 3 -> mem[12]
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'h8B; mem[2] = 8'h20; mem[3] = 8'hAC; mem[4] = 8'hC4;
        mem[10] = 8'd5; mem[11] = 8'd3;
        expect_wr(5'd12, 8'd2);
        do_reset();
        run("arith", 16, 1'b0);
        chk("arith_mem", 32'(mem[12]), 2);

        // wrap: FF + 02 -> 01, ~0F -> F0
        clear_mem();
        mem[0] = 8'h8A; mem[1] = 8'h8B; mem[2] = 8'h00; mem[3] = 8'hAC;
        mem[4] = 8'h8D; mem[5] = 8'h60; mem[6] = 8'hAE; mem[7] = 8'hC7;
        mem[10] = 8'hFF; mem[11] = 8'h02; mem[13] = 8'h0F;
        expect_wr(5'd12, 8'h01);
        expect_wr(5'd14, 8'hF0);
        do_reset();
        run("wrap", 26, 1'b0);

        // branch taken: top == 0
        clear_mem();
        mem[0] = 8'h94; mem[1] = 8'hE7; mem[2] = 8'hC2; mem[7] = 8'hB5; mem[8] = 8'hC8;
        mem[20] = 8'h00; mem[21] = 8'h5A;
        expect_wr(5'd21, 8'h00);
        do_reset();
        step(5);
        chk("jz_taken_pc", 32'(mem_addr), 7);
        run("jz_taken", 5, 1'b0);

        // branch not taken: top == 4
        mem[20] = 8'h04;
        do_reset();
        step(5);
        chk("jz_fall_pc", 32'(mem_addr), 2);
        run("jz_fall", 2, 1'b0);

        // five pushes into a 4-deep stack, then POP
        clear_mem();
        for (int i = 0; i < 5; i++) begin
            mem[i]      = 8'(8'h90 + i);
            mem[16 + i] = 8'(8'h11 + i);
        end
        mem[5] = 8'hB9; mem[6] = 8'hC6;
`ifdef MC_STACK_CHECK_EN
        do_reset();
        run("ovf", 14, 1'b1);

        // ADD with a single operand
        clear_mem();
        mem[0] = 8'h90; mem[1] = 8'h00; mem[2] = 8'hC2; mem[16] = 8'h11;
        do_reset();
        run("udf", 5, 1'b1);
`else
        expect_wr(5'd25, 8'h15);
        do_reset();
        run("wrap_sp", 20, 1'b0);
`endif

        // reset in the STORE cycle drops the write
        clear_mem();
        mem[0] = 8'h90; mem[1] = 8'hB9; mem[2] = 8'hC2; mem[16] = 8'h11; mem[25] = 8'hEE;
        do_reset();
        step(5);
        chk("store_we", 32'(mem_we), 1);
        rst = 1'b1;
        step(1);
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_done", 32'(Done), 0);
        chk("abort_mem", 32'(mem[25]), 32'hEE);
        rst = 1'b0;
        expect_wr(5'd25, 8'h11);
        run("rerun", 8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_mc_core.md
Name: stack_mc_core

Overview:
- Parametrised multicycle stack-machine processor: FSM controller, datapath, internal operand stack and PC in one block, driving an external single-port word memory.
- Generalises the fixed-width stack core: configurable data width, address width and stack depth.
- Adds stack overflow/underflow detection, a halt-on-self-jump convention and an error output.

Parameters:
- DATA_W, 8, data/instruction word width; requires DATA_W >= ADDR_W+3.
- ADDR_W, 5, memory address width; also the PC width.
- DEPTH, 8, operand stack entries; must be a power of two and >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable; the write commits at the clk edge.
- mem_rdata  in  DATA_W  memory read data; combinational (same-cycle) read of mem_addr.
- Done  out  1  high while halted (HALT or ERROR state).
- err  out  1  high while in ERROR state.

Interface rule: one clock; reset is synchronous and active-high (rst sampled on clk rising edge).

Behaviour:
Reset values and reset rules:
- Reset: PC=0, sp=0, state=FETCH, Done=0, err=0, mem_we=0.
- Stack contents are not cleared.
- rst asserted in any state, mid-instruction included, wins: the next state is FETCH and any pending write is dropped.

Instruction format and arithmetic:
- Opcode = IR[DATA_W-1:DATA_W-3]; address = IR[ADDR_W-1:0].
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- A = second-from-top, B = top. SUB computes A-B. All arithmetic wraps modulo 2^DATA_W.
- sp counts 0..DEPTH; the top entry is stack[sp-1].

States and transitions:
- FETCH: mem_addr=PC; IR<=mem_rdata; PC<=PC+1 (wraps modulo 2^ADDR_W) -> DECODE.
- DECODE, by opcode:
  - ADD/SUB/AND: sp<2 -> ERROR, else -> POP_B.
  - NOT: sp<1 -> ERROR, else -> POP_A.
  - PUSH: sp==DEPTH -> ERROR, else -> LOAD.
  - POP: sp==0 -> ERROR, else -> STORE.
  - JMP: if addr == PC-1 (self-jump) -> HALT; else PC<=addr -> FETCH.
  - JZ: sp==0 -> ERROR; else if top==0 then PC<=addr; -> FETCH. JZ does not pop.
- POP_B: B<=stack[sp-1]; sp-- -> POP_A.
- POP_A: A<=stack[sp-1]; sp-- -> EXEC.
- EXEC: stack[sp]<=ALU result (NOT uses A only, i.e. ~A); sp++ -> FETCH.
- LOAD: mem_addr=addr; stack[sp]<=mem_rdata; sp++ -> FETCH.
- STORE: mem_addr=addr; mem_wdata=stack[sp-1]; mem_we=1; sp-- -> FETCH.
- HALT: terminal; Done=1; exited only by rst.
- ERROR: terminal; Done=1, err=1; exited only by rst.

Latency (cycles):
- ADD/SUB/AND: 5. NOT: 4. PUSH/POP: 3. JMP/JZ: 2.
- Entry into HALT/ERROR: 2 cycles after the fetch edge.

Output timing:
- mem_we is high only in STORE; Done/err are registered state decodes.
- Unused mem_wdata is don't-care; mem_addr=PC outside LOAD/STORE.

Optional Feature:
- Macro: MC_STACK_CHECK_EN.
- Defined: the underflow/overflow checks above are active and lead to ERROR.
- Undefined: no checks and ERROR is unreachable; err is tied 0. sp wraps modulo DEPTH; the stack index is sp mod DEPTH; over-pushes overwrite the oldest entry; an under-pop reads stack[DEPTH-1].

Decomposition:
- Package mc_stack_pkg: opcode localparams/enum (OP_ADD..OP_JZ), state enum, opcode field position helpers.
- One sub-module: mc_stack_file. It holds DEPTH x DATA_W storage and sp, with push/pop/wdata ports and outputs top, sp, full and empty.

Test Plan:
- Arithmetic: mem[10]=5, mem[11]=3; program PUSH 10, PUSH 11, SUB, POP 12, JMP self -> mem[12]=2; Done=1; err=0; total cycles = 3+3+5+3+2 = 16.
- Wrap: DATA_W=8, push 0xFF then 0x02, ADD, POP -> stored 0x01. NOT of 0x0F -> 0xF0.
- Branch: top=0 with JZ 7 -> next fetch at PC=7, sp unchanged. With top=4 -> falls through to PC+1.
- Errors (macro on): DEPTH=4, five PUSHes -> err=1 and Done=1 two cycles after the 5th fetch; no mem_we thereafter. ADD with sp=1 -> ERROR.
- Macro off: the same five-PUSH program -> err=0; sp wraps; a subsequent POP returns the 5th pushed value.
- Reset mid-STORE: assert rst in the STORE cycle -> no memory write; next cycle FETCH at PC=0, sp=0, Done=0.
